// File: rtl/multi_edge_capture.sv
// Multi-channel asynchronous edge catcher: input-clocked capture flops, clk-domain event pulse,
// sticky pend/ovr flags with ack, irq. Define EDGE_CNT_EN for per-channel saturating counters.
module multi_edge_capture #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 edge_rst_n,
    input  logic [NCH-1:0]       data_in,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       ack,
    input  logic [NCH-1:0]       cnt_clr,
    input  logic [NCH-1:0]       irq_en,
    output logic [NCH-1:0]       edge_pulse,
    output logic [NCH-1:0]       pend,
    output logic [NCH-1:0]       ovr,
    output logic                 irq,
    output logic [NCH*CNT_W-1:0] cnt
);

    logic [NCH-1:0] cap;
    logic [NCH-1:0] clr_n;
    logic [NCH-1:0] s;
    logic [NCH-1:0] s_d_reg;
    logic [NCH-1:0] clr_req_reg, clr_req_next;
    logic [NCH-1:0] pend_reg, pend_next;
    logic [NCH-1:0] ovr_reg, ovr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic                   rise_reg;
            logic                   fall_reg;
            logic [SYNC_STAGES-1:0] sync_reg;

            // Capture flops stay cleared while the clk domain is acknowledging an event.
            assign clr_n[gi] = edge_rst_n & ~clr_req_reg[gi] & (mode[2*gi +: 2] != 2'b00);

            always_ff @(posedge data_in[gi] or negedge clr_n[gi]) begin
                if (!clr_n[gi]) begin
                    rise_reg <= 1'b0;
                end else if (mode[2*gi]) begin
                    rise_reg <= 1'b1;
                end
            end

            always_ff @(negedge data_in[gi] or negedge clr_n[gi]) begin
                if (!clr_n[gi]) begin
                    fall_reg <= 1'b0;
                end else if (mode[2*gi+1]) begin
                    fall_reg <= 1'b1;
                end
            end

            assign cap[gi] = (rise_reg & mode[2*gi]) | (fall_reg & mode[2*gi+1]);

            always_ff @(posedge clk or negedge edge_rst_n) begin
                if (!edge_rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], cap[gi]};
                end
            end

            assign s[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        edge_pulse   = s & ~s_d_reg;
        // Clear request follows the synchronised capture one cycle late, so it
        // drops only once the cleared capture has propagated back through.
        clr_req_next = s;
        pend_next    = edge_pulse | (pend_reg & ~ack);
        ovr_next     = (edge_pulse & pend_reg & ~ack) | (ovr_reg & ~ack);
    end

    always_ff @(posedge clk or negedge edge_rst_n) begin
        if (!edge_rst_n) begin
            s_d_reg     <= '0;
            clr_req_reg <= '0;
            pend_reg    <= '0;
            ovr_reg     <= '0;
        end else begin
            s_d_reg     <= s;
            clr_req_reg <= clr_req_next;
            pend_reg    <= pend_next;
            ovr_reg     <= ovr_next;
        end
    end

    assign pend = pend_reg;
    assign ovr  = ovr_reg;
    assign irq  = |(pend_reg & irq_en);

`ifdef EDGE_CNT_EN
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_clr[gi]) begin
                    cnt_next = edge_pulse[gi] ? CNT_W'(1) : '0;
                end else if (edge_pulse[gi] && (cnt_reg != '1)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge edge_rst_n) begin
                if (!edge_rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt[CNT_W*gi +: CNT_W] = cnt_reg;
        end
    endgenerate
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = ^cnt_clr;
    assign cnt            = '0;
`endif

endmodule

// File: tb/tb_multi_edge_capture.sv
// Directed bench for multi_edge_capture: event-level model (edge acceptance by spacing,
// fixed latency) checked every cycle, plus literal checks per scenario.
module tb_multi_edge_capture;
    localparam int NCH   = 4;
    localparam int S     = 2;
    localparam int CNT_W = 2;
    localparam int GAP   = 2*S + 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 edge_rst_n;
    logic [NCH-1:0]       data_in, ack, cnt_clr, irq_en;
    logic [2*NCH-1:0]     mode;
    logic [NCH-1:0]       edge_pulse, pend, ovr;
    logic                 irq;
    logic [NCH*CNT_W-1:0] cnt;

    multi_edge_capture #(.NCH(NCH), .SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
        .clk(clk), .edge_rst_n(edge_rst_n), .data_in(data_in), .mode(mode),
        .ack(ack), .cnt_clr(cnt_clr), .irq_en(irq_en), .edge_pulse(edge_pulse),
        .pend(pend), .ovr(ovr), .irq(irq), .cnt(cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: one accepted event per channel at a time, pulse S cycles after the edge's cycle.
    int exp_cyc[NCH]   = '{default: -1};
    int last_ev[NCH]   = '{default: -1000};
    bit pend_m[NCH];
    bit ovr_m[NCH];
    bit prev_pulse[NCH];
    int cnt_m[NCH];
    int npulse[NCH]    = '{default: 0};
    int pulse_cyc[NCH] = '{default: -1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic set_data(input int ch, input logic v);
        logic       old;
        logic [1:0] m;
        bit         en;
        old = data_in[ch];
        m   = mode[2*ch +: 2];
        if (old != v) begin
            en = v ? m[0] : m[1];
            if (en && edge_rst_n && (cyc - last_ev[ch] >= GAP)) begin
                last_ev[ch] = cyc;
                exp_cyc[ch] = cyc + S;
            end
        end
        data_in[ch] = v;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    always @(posedge clk) begin
        logic [NCH-1:0]       e_pulse, e_pend, e_ovr;
        logic [NCH*CNT_W-1:0] e_cnt;
        bit                   cur;
        if (!edge_rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                pend_m[ch] = 0; ovr_m[ch] = 0; prev_pulse[ch] = 0; cnt_m[ch] = 0;
                exp_cyc[ch] = -1; last_ev[ch] = -1000;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                ovr_m[ch]  = (prev_pulse[ch] && pend_m[ch] && !ack[ch]) || (ovr_m[ch] && !ack[ch]);
                pend_m[ch] = prev_pulse[ch] || (pend_m[ch] && !ack[ch]);
`ifdef EDGE_CNT_EN
                if (cnt_clr[ch]) cnt_m[ch] = prev_pulse[ch] ? 1 : 0;
                else if (prev_pulse[ch] && cnt_m[ch] < CMAX) cnt_m[ch] = cnt_m[ch] + 1;
`endif
            end
        end
        cyc = cyc + 1;
        #1;
        e_cnt = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            cur = edge_rst_n && (exp_cyc[ch] == cyc);
            if (cur) exp_cyc[ch] = -1;
            e_pulse[ch]    = cur;
            prev_pulse[ch] = cur;
            e_pend[ch]     = pend_m[ch];
            e_ovr[ch]      = ovr_m[ch];
            e_cnt[ch*CNT_W +: CNT_W] = CNT_W'(cnt_m[ch]);
            if (edge_pulse[ch]) begin
                npulse[ch]    = npulse[ch] + 1;
                pulse_cyc[ch] = cyc;
            end
        end
        chk("edge_pulse", 32'(edge_pulse), 32'(e_pulse));
        chk("pend", 32'(pend), 32'(e_pend));
        chk("ovr", 32'(ovr), 32'(e_ovr));
        chk("irq", 32'(irq), 32'(|(e_pend & irq_en)));
        chk("cnt", 32'(cnt), 32'(e_cnt));
    end

    int base, g;
    logic [CNT_W-1:0] c0;

    initial begin
        edge_rst_n = 1'b1;
        data_in = '0; mode = '0; ack = '0; cnt_clr = '0; irq_en = '0;
        #1 edge_rst_n = 1'b0;
        step(3);
        chk("reset_pend", 32'(pend), 32'h0);
        chk("reset_cnt", 32'(cnt), 32'h0);
        edge_rst_n = 1'b1;
        step(2);

        // Sub-cycle glitch on rising-edge channel
        mode[1:0] = 2'b01; irq_en[0] = 1'b1;
        step(2);
        base = npulse[0]; g = cyc;
        set_data(0, 1'b1); #3; set_data(0, 1'b0);
        step(10);
        chk("glitch_pulses", 32'(npulse[0] - base), 32'd1);
        chk("glitch_latency", 32'(pulse_cyc[0] - g), 32'd2);
        chk("glitch_pend", 32'(pend[0]), 32'd1);
        chk("glitch_irq", 32'(irq), 32'd1);
        ack[0] = 1'b1; step(1); ack[0] = 1'b0; step(1);

        // Three falling edges, no ack -> overrun; then ack clears both
        mode[3:2] = 2'b10;
        step(2);
        base = npulse[1];
        for (int k = 0; k < 3; k++) begin
            set_data(1, 1'b1); step(5); set_data(1, 1'b0); step(5);
        end
        step(10);
        chk("fall_pulses", 32'(npulse[1] - base), 32'd3);
        chk("fall_pend", 32'(pend[1]), 32'd1);
        chk("fall_ovr", 32'(ovr[1]), 32'd1);
        ack[1] = 1'b1; step(1); ack[1] = 1'b0;
        chk("ack_pend", 32'(pend[1]), 32'd0);
        chk("ack_ovr", 32'(ovr[1]), 32'd0);

        // Ack coincident with a pulse: pend stays, ovr not raised
        for (int k = 0; k < 2; k++) begin
            step(10);
            set_data(1, 1'b1); step(5); set_data(1, 1'b0); step(2);
            ack[1] = 1'b1; step(1); ack[1] = 1'b0;
            chk("ackpulse_pend", 32'(pend[1]), 32'd1);
            chk("ackpulse_ovr", 32'(ovr[1]), 32'd0);
        end
        ack[1] = 1'b1; step(1); ack[1] = 1'b0; step(2);

        // Both-edge mode: a long pulse gives two events; mode off gives none
        mode[5:4] = 2'b11;
        step(2);
        base = npulse[2];
        set_data(2, 1'b1); step(20); set_data(2, 1'b0); step(10);
        chk("both_pulses", 32'(npulse[2] - base), 32'd2);
        mode[5:4] = 2'b00;
        step(2);
        base = npulse[2];
        set_data(2, 1'b1); step(20); set_data(2, 1'b0); step(10);
        chk("off_pulses", 32'(npulse[2] - base), 32'd0);

        // Two rising edges 3 cycles apart collapse to one event
        mode[7:6] = 2'b01;
        step(2);
        base = npulse[3];
        set_data(3, 1'b1); step(1); set_data(3, 1'b0); step(2); set_data(3, 1'b1);
        step(10); set_data(3, 1'b0); step(10);
        chk("close_pulses", 32'(npulse[3] - base), 32'd1);

        // Counter saturation and clear-with-pulse on ch0
        cnt_clr[0] = 1'b1; step(1); cnt_clr[0] = 1'b0; step(2);
        for (int k = 0; k < 5; k++) begin
            set_data(0, 1'b1); step(5); set_data(0, 1'b0); step(5);
        end
        step(5);
        c0 = cnt[CNT_W-1:0];
`ifdef EDGE_CNT_EN
        chk("cnt_saturate", 32'(c0), 32'd3);
`else
        chk("cnt_absent", 32'(c0), 32'd0);
`endif
        set_data(0, 1'b1); step(2);
        cnt_clr[0] = 1'b1; step(1); cnt_clr[0] = 1'b0;
        c0 = cnt[CNT_W-1:0];
`ifdef EDGE_CNT_EN
        chk("cnt_clr_pulse", 32'(c0), 32'd1);
`else
        chk("cnt_clr_absent", 32'(c0), 32'd0);
`endif
        set_data(0, 1'b0); step(10);

        // Reset one cycle after an edge: everything clears, no late pulse
        base = npulse[0];
        set_data(0, 1'b1); step(1);
        edge_rst_n = 1'b0; step(1);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pulse", 32'(edge_pulse), 32'h0);
        edge_rst_n = 1'b1; step(10);
        chk("rst_no_pulse", 32'(npulse[0] - base), 32'd0);
        set_data(0, 1'b0); step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
